// File: rtl/startup_pkg.sv
// startup_pkg: shared state encoding and default constants for the startup sequencer
package startup_pkg;
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, ROC = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;
  localparam int DEF_N_CHANNELS = 4;
  localparam int DEF_CNT_WIDTH = 20;
  localparam int DEF_ROC_CYCLES = 1000;
  localparam int DEF_TOC_CYCLES = 0;
  localparam int DEF_STAGE_CYCLES = 16;
  localparam int DEF_LOCK_FILTER = 8;
endpackage

// File: rtl/lock_filter.sv
// lock_filter: qualifies pll_locked after LOCK_FILTER consecutive high cycles
module lock_filter import startup_pkg::*; #(
  parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic pll_locked,
  output logic qualified
);
  localparam int W = $clog2(LOCK_FILTER + 1);
  localparam logic [W-1:0] TGT = W'(LOCK_FILTER);
  logic [W-1:0] cnt;
  always_ff @(posedge sys_clk)
    if (sys_rst || clr || !pll_locked) cnt <= '0;
    else if (cnt != TGT) cnt <= cnt + 1'b1;
  assign qualified = cnt == TGT;
endmodule

// File: rtl/startup_sequencer.sv
// startup_sequencer: lock-qualified GSR/GTS release followed by staggered per-channel reset release
module startup_sequencer import startup_pkg::*; #(
  parameter int N_CHANNELS = DEF_N_CHANNELS,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int ROC_CYCLES = DEF_ROC_CYCLES,
  parameter int TOC_CYCLES = DEF_TOC_CYCLES,
  parameter int STAGE_CYCLES = DEF_STAGE_CYCLES,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  pll_locked,
  input  logic                  soft_req,
  output logic                  gsr,
  output logic                  prld,
  output logic                  gts,
  output logic [N_CHANNELS-1:0] chan_rst,
  output logic                  done,
  output logic [1:0]            state
);
  localparam longint MAXC = (longint'(1) << CNT_WIDTH) - 1;
  localparam logic [CNT_WIDTH-1:0] ROC_LAST = CNT_WIDTH'(ROC_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REL_LAST = CNT_WIDTH'((N_CHANNELS - 1) * STAGE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TOC = CNT_WIDTH'(TOC_CYCLES);
  if (N_CHANNELS < 1 || N_CHANNELS > 16 || ROC_CYCLES < 1 || TOC_CYCLES < 0 ||
      STAGE_CYCLES < 1 || LOCK_FILTER < 1 || longint'(ROC_CYCLES) > MAXC ||
      longint'(TOC_CYCLES) > MAXC || longint'(STAGE_CYCLES) > MAXC ||
      longint'(LOCK_FILTER) > MAXC || longint'((N_CHANNELS - 1) * STAGE_CYCLES) > MAXC) begin : g_bad_param
    $error("startup_sequencer: parameter out of range for CNT_WIDTH");
  end
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, gts_cnt_q, gts_cnt_d;
  logic [N_CHANNELS-1:0] chan_d;
  logic qualified, lost;
  lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr(state_q != WAIT_LOCK),
    .pll_locked(pll_locked),
    .qualified(qualified)
  );
  always_comb begin
    lost = !pll_locked || (state_q == RUN && soft_req);
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: state_d = qualified ? ROC : WAIT_LOCK;
      ROC:       state_d = lost ? WAIT_LOCK : cnt_q == ROC_LAST ? RELEASE : ROC;
      RELEASE:   state_d = lost ? WAIT_LOCK : cnt_q == REL_LAST ? RUN : RELEASE;
      default:   state_d = lost ? WAIT_LOCK : RUN;
    endcase
    cnt_d = (state_d != state_q || state_q inside {WAIT_LOCK, RUN}) ? '0 :
            cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
    // gts timing runs from ROC entry regardless of how far the FSM has progressed
    gts_cnt_d = (state_q == WAIT_LOCK || state_d == WAIT_LOCK) ? '0 :
                gts_cnt_q >= TOC ? gts_cnt_q : gts_cnt_q + 1'b1;
  end
  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
    assign chan_d[i] = state_d == RUN ? 1'b0 :
                       state_d == RELEASE ? cnt_d < CNT_WIDTH'(i * STAGE_CYCLES) : 1'b1;
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state_q <= WAIT_LOCK;
      cnt_q <= '0;
      gts_cnt_q <= '0;
      gsr <= 1'b1;
      gts <= 1'b1;
      chan_rst <= '1;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gts_cnt_q <= gts_cnt_d;
      gsr <= state_d inside {WAIT_LOCK, ROC};
      gts <= state_d == WAIT_LOCK || gts_cnt_d < TOC;
      chan_rst <= chan_d;
      done <= state_d == RUN;
    end
  assign prld = gsr;
  assign state = state_q;
endmodule

// File: tb/tb_startup_sequencer.sv
// tb_startup_sequencer: directed and random checks against a timeline model of the sequencer
module tb_startup_sequencer;
  localparam int N = 4, CW = 8, ROC = 10, TOC = 3, STG = 2, LF = 4;
  localparam int REL_END = ROC + (N - 1) * STG;
  logic clk = 0, sys_rst = 1, pll_locked = 0, soft_req = 0;
  logic gsr0, prld0, gts0, done0, gsr1, prld1, gts1, done1;
  logic [N-1:0] ch0, ch1;
  logic [1:0] st0, st1;
  logic [9:0] v0, v1;
  int checks = 0, errors = 0, cyc = 0, ones = 0, t = 0;
  bit chk_en = 0, waiting = 1;
  logic [7:0] pat = 8'b1111_0111;
  assign v0 = {st0, gsr0, prld0, gts0, ch0, done0};
  assign v1 = {st1, gsr1, prld1, gts1, ch1, done1};
  startup_sequencer #(.N_CHANNELS(N), .CNT_WIDTH(CW), .ROC_CYCLES(ROC), .TOC_CYCLES(TOC),
    .STAGE_CYCLES(STG), .LOCK_FILTER(LF)) u0 (
    .sys_clk(clk), .sys_rst(sys_rst), .pll_locked(pll_locked), .soft_req(soft_req),
    .gsr(gsr0), .prld(prld0), .gts(gts0), .chan_rst(ch0), .done(done0), .state(st0));
  startup_sequencer #(.N_CHANNELS(N), .CNT_WIDTH(CW), .ROC_CYCLES(ROC), .TOC_CYCLES(0),
    .STAGE_CYCLES(STG), .LOCK_FILTER(LF)) u1 (
    .sys_clk(clk), .sys_rst(sys_rst), .pll_locked(pll_locked), .soft_req(soft_req),
    .gsr(gsr1), .prld(prld1), .gts(gts1), .chan_rst(ch1), .done(done1), .state(st1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // timeline model: waiting for lock, or t cycles elapsed since ROC entry
  always @(posedge clk)
    if (sys_rst) begin
      waiting = 1;
      ones = 0;
    end else if (waiting) begin
      if (ones >= LF) begin
        waiting = 0;
        t = 0;
      end else ones = pll_locked ? ones + 1 : 0;
    end else if (!pll_locked || (soft_req && t > REL_END)) begin
      waiting = 1;
      ones = 0;
    end else t++;
  function automatic logic [9:0] model_vec(input int toc);
    logic [N-1:0] ch;
    logic [1:0] st;
    logic g;
    for (int i = 0; i < N; i++) ch[i] = waiting || t < ROC + i * STG;
    st = waiting ? 2'd0 : t < ROC ? 2'd1 : t <= REL_END ? 2'd2 : 2'd3;
    g = waiting || t < ROC;
    return {st, g, g, waiting || t < toc, ch, st == 2'd3};
  endfunction
  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("model_toc3", v0, model_vec(TOC));
      chk("model_toc0", v1, model_vec(0));
    end
  task automatic drive(input logic r, input logic l, input logic s);
    sys_rst = r;
    pll_locked = l;
    soft_req = s;
    @(negedge clk);
  endtask
  // k counts cycles from a cleared WAIT_LOCK with pll_locked held high; T is k=5
  task automatic run_seq(input int n, input int soft_at);
    for (int k = 1; k <= n; k++) begin
      drive(0, 1, k == soft_at);
      case (k)
        4:  chk("seq_wait", v0, 10'b00_111_1111_0);
        5:  begin
          chk("seq_T", v0, 10'b01_111_1111_0);
          chk("toc0_T", v1, 10'b01_110_1111_0);
        end
        7:  chk("seq_T2", v0, 10'b01_111_1111_0);
        8:  chk("seq_T3_gts", v0, 10'b01_110_1111_0);
        14: chk("seq_T9", v0, 10'b01_110_1111_0);
        15: begin
          chk("seq_T10_gsr", v0, 10'b10_000_1110_0);
          chk("toc0_T10", v1, 10'b10_000_1110_0);
        end
        17: chk("seq_T12_ch1", v0, 10'b10_000_1100_0);
        19: chk("seq_T14_ch2", v0, 10'b10_000_1000_0);
        21: chk("seq_T16_ch3", v0, 10'b10_000_0000_0);
        22: chk("seq_T17_done", v0, 10'b11_000_0000_1);
        default: ;
      endcase
    end
  endtask
  initial begin
    drive(1, 0, 0);
    chk_en = 1;
    chk("reset", v0, 10'b00_111_1111_0);
    drive(1, 0, 0);
    run_seq(24, 11);
    drive(0, 1, 1);
    chk("soft_run", v0, 10'b00_111_1111_0);
    run_seq(24, 0);
    drive(0, 0, 0);
    run_seq(17, 0);
    drive(0, 0, 0);
    chk("loss_release", v0, 10'b00_111_1111_0);
    run_seq(24, 0);
    drive(0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      drive(0, pat[j], 0);
      chk("glitch_wait", v0, 10'b00_111_1111_0);
    end
    drive(0, 1, 0);
    chk("glitch_roc", v0, 10'b01_111_1111_0);
    repeat (4) drive(0, 1, 0);
    drive(1, 1, 0);
    chk("rst_mid_roc", v0, 10'b00_111_1111_0);
    run_seq(24, 0);
    drive(1, 0, 0);
    run_seq(16, 0);
    drive(1, 1, 0);
    chk("rst_mid_release", v0, 10'b00_111_1111_0);
    run_seq(24, 0);
    repeat (3000) drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 97, $urandom_range(0, 99) < 3);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/startup_sequencer.md
STARTUP_SEQUENCER -- requirements
Module: startup_sequencer

Interface
REQ-001 The block SHALL have parameter N_CHANNELS, default 4, meaning the number of sequenced reset outputs (1..16).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 20, meaning the width of all internal cycle counters.
REQ-003 The block SHALL have parameter ROC_CYCLES, default 1000, meaning the global-reset (GSR/PRLD) hold time in ROC state, in cycles (≥1).
REQ-004 The block SHALL have parameter TOC_CYCLES, default 0, meaning the tristate (GTS) hold time counted from ROC entry, in cycles (≥0).
REQ-005 The block SHALL have parameter STAGE_CYCLES, default 16, meaning the spacing between successive channel releases, in cycles (≥1).
REQ-006 The block SHALL have parameter LOCK_FILTER, default 8, meaning the number of consecutive pll_locked-high cycles required to qualify lock (≥1).
REQ-007 sys_clk  input  1  the single clock; all logic is on its rising edge.
REQ-008 sys_rst  input  1  reset; synchronous and active-high.
REQ-009 pll_locked  input  1  raw lock indication, already synchronous to sys_clk.
REQ-010 soft_req  input  1  re-sequence request; one-cycle pulse is sufficient.
REQ-011 gsr  output  1  global set/reset, active-high.
REQ-012 prld  output  1  preload, active-high; always equal to gsr.
REQ-013 gts  output  1  global tristate, active-high.
REQ-014 chan_rst  output  N_CHANNELS  per-domain resets, active-high.
REQ-015 done  output  1  high when every channel is released.
REQ-016 state  output  2  current FSM state encoding, for debug.

Function
REQ-017 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-018 The FSM SHALL have four states: WAIT_LOCK=0, ROC=1, RELEASE=2, RUN=3.
REQ-019 In WAIT_LOCK, a filter counter SHALL increment while pll_locked=1 and clear to 0 on any pll_locked=0 cycle; the FSM SHALL move to ROC on the cycle after the counter reaches LOCK_FILTER.
REQ-020 ROC SHALL last exactly ROC_CYCLES cycles; gsr and prld SHALL be 1 in WAIT_LOCK and ROC, and 0 from the first RELEASE cycle onward.
REQ-021 The GTS counter SHALL start on ROC entry; gts SHALL fall TOC_CYCLES cycles after ROC entry, independent of state progress; with TOC_CYCLES=0, gts SHALL be 0 on the first ROC cycle.
REQ-022 chan_rst[i] SHALL fall on RELEASE cycle i*STAGE_CYCLES, counting the first RELEASE cycle as 0; channels SHALL release in ascending index order and never out of order.
REQ-023 The FSM SHALL enter RUN on the cycle after chan_rst[N_CHANNELS-1] falls; done SHALL be 1 only in RUN.
REQ-024 pll_locked=0 in ROC, RELEASE or RUN SHALL force WAIT_LOCK on the next cycle, with gsr=prld=gts=1, all chan_rst=1, done=0, and all counters cleared.
REQ-025 soft_req=1 in RUN SHALL act as a lock loss (REQ-024); soft_req SHALL be ignored in every other state.
REQ-026 When lock loss and soft_req coincide, the result SHALL be identical to lock loss alone.
REQ-027 Counters SHALL saturate and never wrap; elaboration SHALL fail if any parameter value exceeds 2^CNT_WIDTH-1.

Reset
REQ-028 The block SHALL reset to: state=WAIT_LOCK, gsr=prld=gts=1, chan_rst all 1, done=0, all counters 0.
REQ-029 sys_rst asserted in any state, including mid-ROC or mid-RELEASE, SHALL produce the reset values on the next sys_clk edge.
REQ-030 The block SHALL resume sequencing from WAIT_LOCK on the first cycle sys_rst is low.

Structure
REQ-031 The state encoding and the default parameter constants SHALL live in the shared package startup_pkg.
REQ-032 The lock qualifier SHALL be the sub-module lock_filter, with ports sys_clk, sys_rst, clr, pll_locked, qualified, and parameter LOCK_FILTER.
REQ-033 The RTL SHALL be synthesizable and SHALL contain no delays or initial blocks.

Verification
All scenarios use N_CHANNELS=4, ROC_CYCLES=10, TOC_CYCLES=3, STAGE_CYCLES=2, LOCK_FILTER=4; T = the first ROC cycle.
REQ-034 Nominal: pll_locked held at 1 -> gts falls at T+3; gsr/prld fall at T+10; chan_rst[0..3] fall at T+10, T+12, T+14, T+16; done rises at T+17.
REQ-035 Lock glitch: pll_locked 1,1,1,0,1,1,1,1 -> ROC entered only after the last four 1s; gsr stays 1 throughout.
REQ-036 Lock loss during RELEASE, just after chan_rst[1] falls -> next cycle all chan_rst=1, gsr=gts=1, state=0, done=0; full sequence repeats once lock is requalified.
REQ-037 soft_req in RUN -> identical re-sequence to REQ-036; soft_req pulsed at T+5 -> no effect.
REQ-038 sys_rst pulsed at T+4 -> next cycle matches the reset values of REQ-028; sequence restarts from the lock filter.
REQ-039 TOC_CYCLES=0 variant -> gts=0 at T while gsr remains 1 until T+10.
